// File: rtl/block_memory.sv
// Block memory: whole-block main-memory stage behind the cache, one access at a time.
// Latency: ack pulses LATENCY cycles after the accepting edge's cycle (LATENCY+1 per back-to-back op).
// Backpressure: none; requests are only sampled in IDLE, so held cs simply waits its turn.
//
// Ports:
//   clk, rst_n        clock (posedge) and asynchronous active-low reset
//   mem_req           cs, rw (1=write), addr, data[BLOCK_SIZE]
//   mem_res           ack (1-cycle pulse), data[BLOCK_SIZE] (last read block)
//   rd_count/wr_count completed reads/writes, saturating; only with BLOCK_MEMORY_STATS_EN

package cache_parameters;
  localparam int WORD_WIDTH   = 32;
  localparam int BLOCK_SIZE   = 4;
  localparam int OFFSET_WIDTH = 2;
  localparam int LINE_WIDTH   = 4;
  localparam int TAG_WIDTH    = 4;
  localparam int ADDR_WIDTH   = TAG_WIDTH + LINE_WIDTH + OFFSET_WIDTH;
  localparam int LINE_LSB     = OFFSET_WIDTH;
  localparam int TAG_MSB      = ADDR_WIDTH - 1;

  typedef logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] block_t;

  typedef struct packed {
    logic                  cs;
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    block_t                data;
  } memory_request_t;

  typedef struct packed {
    logic   ack;
    block_t data;
  } memory_response_t;
endpackage

module block_memory
  import cache_parameters::*;
#(
  parameter int MEM_BLOCKS = 2 ** (TAG_WIDTH + LINE_WIDTH),
  parameter int LATENCY    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  memory_request_t  mem_req,
  output memory_response_t mem_res
`ifdef BLOCK_MEMORY_STATS_EN
  ,
  output logic [31:0]      rd_count,
  output logic [31:0]      wr_count
`endif
);

  localparam int IDX_W      = $clog2(MEM_BLOCKS);
  localparam int FULL_IDX_W = TAG_WIDTH + LINE_WIDTH;
  localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              lat_rw;
  logic [IDX_W-1:0]  lat_idx;
  block_t            lat_data;
  block_t            rd_data;

  // Zero at time 0; reset deliberately leaves contents alone.
  block_t            mem [MEM_BLOCKS] = '{default: '0};

  // Tag+line field, truncated so out-of-range indices wrap.
  logic [FULL_IDX_W-1:0] full_idx;
  logic [IDX_W-1:0]      req_idx;
  assign full_idx = mem_req.addr[TAG_MSB:LINE_LSB];
  assign req_idx  = full_idx[IDX_W-1:0];

  // Offset bits and wrapped-off index bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_req.addr, full_idx};

  logic accept;
  logic enter_resp;
  assign accept     = rst_n && (state == IDLE) && mem_req.cs;
  assign enter_resp = rst_n && ((accept && (LATENCY == 1)) ||
                                ((state == BUSY) && (cnt == CNT_W'(1))));

  // With LATENCY=1 the access completes on the accepting edge, before the
  // latch registers hold the request, so take the live request in that case.
  logic             op_rw;
  logic [IDX_W-1:0] op_idx;
  block_t           op_data;
  always_comb begin
    op_rw   = lat_rw;
    op_idx  = lat_idx;
    op_data = lat_data;
    if (state == IDLE) begin
      op_rw   = mem_req.rw;
      op_idx  = req_idx;
      op_data = mem_req.data;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mem_req.cs) state_nxt = (LATENCY == 1) ? RESP : BUSY;
      BUSY: if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_res.ack  = (state == RESP);
    mem_res.data = rd_data;
  end

  // Latency counter and request latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      lat_rw   <= 1'b0;
      lat_idx  <= '0;
      lat_data <= '0;
    end else if (accept) begin
      cnt      <= CNT_W'(LATENCY - 1);
      lat_rw   <= mem_req.rw;
      lat_idx  <= req_idx;
      lat_data <= mem_req.data;
    end else if (state == BUSY) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Read data register: holds the last completed read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     rd_data <= '0;
    else if (enter_resp && !op_rw)  rd_data <= mem[op_idx];
  end

  // Array write commits on the edge entering RESP; gating with rst_n in
  // enter_resp keeps an aborted write from landing.
  always_ff @(posedge clk) begin
    if (enter_resp && op_rw) mem[op_idx] <= op_data;
  end

`ifdef BLOCK_MEMORY_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (enter_resp) begin
      if (op_rw) begin
        if (wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
      end else begin
        if (rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_block_memory.sv
// Directed bench for block_memory (LATENCY=3, MEM_BLOCKS=16).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Stats checks are included when BLOCK_MEMORY_STATS_EN is defined.
module tb_block_memory;
  import cache_parameters::*;

  localparam int LAT = 3;
  localparam int MB  = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  memory_request_t  mem_req;
  memory_response_t mem_res;
`ifdef BLOCK_MEMORY_STATS_EN
  logic [31:0]      rd_count;
  logic [31:0]      wr_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  block_memory #(.MEM_BLOCKS(MB), .LATENCY(LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mem_req (mem_req),
    .mem_res (mem_res)
`ifdef BLOCK_MEMORY_STATS_EN
    ,
    .rd_count(rd_count),
    .wr_count(wr_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic block_t mk(input int a, input int b, input int c, input int d);
    block_t blk;
    blk[0] = 32'(a);
    blk[1] = 32'(b);
    blk[2] = 32'(c);
    blk[3] = 32'(d);
    return blk;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] mkaddr(input int idx, input int off);
    return ADDR_WIDTH'((idx << OFFSET_WIDTH) | off);
  endfunction

  // One access: cs held until ack, dropped in the ack cycle. After the
  // accepting edge the request bus is scrambled; the DUT must use its latch.
  // lat = number of edges from cs assertion to ack visible (-1 on timeout).
  task automatic do_op(input logic rw, input logic [ADDR_WIDTH-1:0] addr, input block_t d,
                       output int lat, output block_t rdata);
    mem_req.cs   = 1'b1;
    mem_req.rw   = rw;
    mem_req.addr = addr;
    mem_req.data = d;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) begin
        mem_req.addr = ~addr;
        mem_req.data = ~d;
      end
      if (mem_res.ack) begin
        lat = i;
        break;
      end
    end
    mem_req.cs   = 1'b0;
    mem_req.data = '0;
    rdata = mem_res.data;
    tick();
  endtask

  task automatic test_reset();
    int     lat;
    block_t rd;
    rst_n        = 1'b0;
    mem_req.cs   = 1'b1;
    mem_req.rw   = 1'b0;
    mem_req.addr = mkaddr(1, 0);
    repeat (3) tick();
    tests++;
    if (mem_res.ack !== 1'b0) begin
      fails++; $display("FAIL reset_ack: got %b want 0", mem_res.ack);
    end
    tests++;
    if (mem_res.data !== '0) begin
      fails++; $display("FAIL reset_data: got %h want 0", mem_res.data);
    end
    rst_n = 1'b1;
    do_op(1'b0, mkaddr(1, 0), '0, lat, rd);
    tests++;
    if (lat !== LAT) begin
      fails++; $display("FAIL reset_first_latency: got %0d want %0d", lat, LAT);
    end
    tests++;
    if (rd !== '0) begin
      fails++; $display("FAIL reset_first_read: got %h want 0", rd);
    end
    tests++;
    if (mem_res.ack !== 1'b0) begin
      fails++; $display("FAIL reset_ack_pulse: got %b want 0", mem_res.ack);
    end
  endtask

  task automatic test_write_read();
    int     lat;
    block_t rd;
    do_op(1'b1, mkaddr('h12, 1), mk(1, 2, 3, 4), lat, rd);
    tests++;
    if (lat !== LAT) begin
      fails++; $display("FAIL wr_latency: got %0d want %0d", lat, LAT);
    end
    do_op(1'b0, mkaddr('h12, 0), '0, lat, rd);
    tests++;
    if (rd !== mk(1, 2, 3, 4)) begin
      fails++; $display("FAIL rd_0x12: got %h want %h", rd, mk(1, 2, 3, 4));
    end
    // A write must leave the response data holding the previous read.
    do_op(1'b1, mkaddr('h14, 0), mk(7, 7, 7, 7), lat, rd);
    tests++;
    if (rd !== mk(1, 2, 3, 4)) begin
      fails++; $display("FAIL wr_keeps_data: got %h want %h", rd, mk(1, 2, 3, 4));
    end
    // Read straight after the write to the same index.
    do_op(1'b0, mkaddr('h14, 2), '0, lat, rd);
    tests++;
    if (rd !== mk(7, 7, 7, 7)) begin
      fails++; $display("FAIL rd_after_wr: got %h want %h", rd, mk(7, 7, 7, 7));
    end
    do_op(1'b0, mkaddr('h13, 0), '0, lat, rd);
    tests++;
    if (rd !== '0) begin
      fails++; $display("FAIL rd_untouched_0x13: got %h want 0", rd);
    end
  endtask

  task automatic test_handshake();
    int     lat;
    block_t rd;
    int     acks;
    int     first;
    int     second;
    do_op(1'b0, mkaddr('h12, 0), '0, lat, rd);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_res.ack) acks++;
    end
    tests++;
    if (acks !== 0) begin
      fails++; $display("FAIL hs_no_retrigger: got %0d acks want 0", acks);
    end
    // cs held through ack: a second access starts from IDLE.
    mem_req.cs   = 1'b1;
    mem_req.rw   = 1'b0;
    mem_req.addr = mkaddr('h12, 0);
    first  = -1;
    second = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (mem_res.ack) begin
        if (first < 0) begin
          first = i;
        end else begin
          second = i;
          mem_req.cs = 1'b0;
          break;
        end
      end
    end
    mem_req.cs = 1'b0;
    tests++;
    if (first !== LAT) begin
      fails++; $display("FAIL hs_held_first: got %0d want %0d", first, LAT);
    end
    tests++;
    if (second - first !== LAT + 1) begin
      fails++; $display("FAIL hs_held_spacing: got %0d want %0d", second - first, LAT + 1);
    end
    tests++;
    if (mem_res.data !== mk(1, 2, 3, 4)) begin
      fails++; $display("FAIL hs_held_data: got %h want %h", mem_res.data, mk(1, 2, 3, 4));
    end
    repeat (2) tick();
  endtask

  task automatic test_wrap_offset();
    int     lat;
    block_t rd;
    do_op(1'b1, mkaddr('h25, 3), mk('hA, 'hB, 'hC, 'hD), lat, rd);
    do_op(1'b0, mkaddr('h05, 0), '0, lat, rd);
    tests++;
    if (rd !== mk('hA, 'hB, 'hC, 'hD)) begin
      fails++; $display("FAIL wrap_0x25_to_0x05: got %h want %h", rd, mk('hA, 'hB, 'hC, 'hD));
    end
  endtask

  task automatic test_reset_mid_write();
    int     lat;
    block_t rd;
    int     acks;
    acks = 0;
    mem_req.cs   = 1'b1;
    mem_req.rw   = 1'b1;
    mem_req.addr = mkaddr(7, 0);
    mem_req.data = mk(9, 9, 9, 9);
    tick();
    if (mem_res.ack) acks++;
    tick();
    if (mem_res.ack) acks++;
    tests++;
    if (acks !== 0) begin
      fails++; $display("FAIL midwr_no_ack: got %0d acks want 0", acks);
    end
    rst_n      = 1'b0;
    mem_req.cs = 1'b0;
    #2;
    tests++;
    if (mem_res.data !== '0) begin
      fails++; $display("FAIL midwr_async_data: got %h want 0", mem_res.data);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_op(1'b0, mkaddr(7, 0), '0, lat, rd);
    tests++;
    if (rd !== '0) begin
      fails++; $display("FAIL midwr_not_committed: got %h want 0", rd);
    end
    do_op(1'b0, mkaddr('h12, 0), '0, lat, rd);
    tests++;
    if (rd !== mk(1, 2, 3, 4)) begin
      fails++; $display("FAIL reset_keeps_array: got %h want %h", rd, mk(1, 2, 3, 4));
    end
  endtask

`ifdef BLOCK_MEMORY_STATS_EN
  task automatic test_stats();
    int     lat;
    block_t rd;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (rd_count !== 32'd0 || wr_count !== 32'd0) begin
      fails++; $display("FAIL stats_reset: got rd=%0d wr=%0d want 0/0", rd_count, wr_count);
    end
    do_op(1'b0, mkaddr(1, 0), '0, lat, rd);
    do_op(1'b1, mkaddr(2, 0), mk(1, 1, 1, 1), lat, rd);
    do_op(1'b0, mkaddr(3, 0), '0, lat, rd);
    do_op(1'b1, mkaddr(4, 0), mk(2, 2, 2, 2), lat, rd);
    do_op(1'b0, mkaddr(2, 0), '0, lat, rd);
    tests++;
    if (rd_count !== 32'd3) begin
      fails++; $display("FAIL stats_rd: got %0d want 3", rd_count);
    end
    tests++;
    if (wr_count !== 32'd2) begin
      fails++; $display("FAIL stats_wr: got %0d want 2", wr_count);
    end
    rst_n = 1'b0;
    #2;
    tests++;
    if (rd_count !== 32'd0 || wr_count !== 32'd0) begin
      fails++; $display("FAIL stats_clear: got rd=%0d wr=%0d want 0/0", rd_count, wr_count);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_req = '0;
    rst_n   = 1'b0;
    test_reset();
    test_write_read();
    test_handshake();
    test_wrap_offset();
    test_reset_mid_write();
`ifdef BLOCK_MEMORY_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
